if_fetch_unit: RTL

- Instruction fetch front end: owns the program counter and issues requests to instruction memory.
- Buffers returned instructions in a small prefetch queue and presents {pc, instr} to the IF/ID pipeline register.
- Takes jump redirects from later stages, generates the flush pulse for IF/ID, and discards stale in-flight fetches.

---
 rtl/if_fetch_unit_pkg.sv | 15 +
 rtl/if_fetch_queue.sv | 47 ++++
 rtl/if_fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types and default widths, also used by the IF/ID register and decode.
// Holds the fetch FSM state type and the NOP encoding presented when the prefetch queue is empty.
package if_fetch_unit_pkg;

  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 8;
  localparam int NOP_INSTR   = 0;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Prefetch FIFO of {pc, instr}: head is visible combinationally, push lands one cycle later.
// No internal backpressure; the caller reserves a slot before pushing. Clear beats push and pop.
module if_fetch_queue #(
  parameter int W     = 16,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: nothing reads it while count is zero.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the PC, issues imem requests, queues {pc, instr} for IF/ID, handles redirect/flush.
// First instr 2 cycles after reset; stall holds the head and requests stop when no free slot. Stats: IF_FETCH_STATS_EN.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               flush_out
`ifdef IF_FETCH_STATS_EN
  ,
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        discard_cnt
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [PC_W-1:0] req_addr;
  logic [CW-1:0]   count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            push;
  logic            pop;

  // The request line is a decode of the state register, so it is glitch-free and drops on reset.
  assign imem_req    = (state != FETCH);
  assign imem_addr   = req_addr;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && !stall && !redirect;
  assign push        = (state == WAIT) && imem_ack && !redirect;
  assign push_entry  = '{pc: fetch_pc, instr: imem_rdata};
  assign pc_out      = instr_valid ? head.pc : '0;
  assign instr_out   = instr_valid ? head.instr : INSTR_W'(NOP_INSTR);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      FETCH: begin
        if (!redirect && int'(count) < QDEPTH) state_nxt = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          state_nxt = imem_ack ? FETCH : DISCARD;
        end else if (imem_ack) begin
          fetch_pc_nxt = fetch_pc + PC_W'(1);
          // Back-to-back issue only if the next request still has a slot reserved for it.
          if (int'(count) + 1 - int'(pop) >= QDEPTH) state_nxt = FETCH;
        end
      end
      DISCARD: begin
        if (imem_ack) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    if (redirect) fetch_pc_nxt = redirect_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      req_addr  <= RESET_PC;
      flush_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      flush_out <= redirect;
      // Latched separately so a redirect cannot move the address of an in-flight request.
      if (state_nxt == WAIT) req_addr <= fetch_pc_nxt;
    end
  end

  if_fetch_queue #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .din   (push_entry),
    .count (count),
    .head  (head)
  );

`ifdef IF_FETCH_STATS_EN
  logic drop;
  assign drop = imem_ack && ((state == WAIT && redirect) || state == DISCARD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      if (push && fetch_cnt != 16'hFFFF)   fetch_cnt   <= fetch_cnt + 16'd1;
      if (drop && discard_cnt != 16'hFFFF) discard_cnt <= discard_cnt + 16'd1;
    end
  end
`endif

endmodule
